// File: rtl/serial_add_ctrl.sv
// Bit-serial unsigned adder sequencer: drives one full-adder cell built from
// two half adders, one operand bit per clock, with start/busy/done handshake.

module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sh_a, sh_b, res, res_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             accept, last;
    logic             p, g1, s, g2, carry_nxt;

    // New operands are taken only when no addition is in flight.
    assign accept = start && (state == IDLE || state == DONE);
    assign last   = (cnt == CW'(WIDTH - 1));

    half_adder u_ha0 (.a(sh_a[0]), .b(sh_b[0]), .s(p), .c(g1));
    half_adder u_ha1 (.a(p),       .b(carry),   .s(s), .c(g2));
    assign carry_nxt = g1 | g2;

    // Sum bits enter from the MSB side so the LSB lands at bit 0 after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_res1
            assign res_nxt = s;
        end else begin : g_resn
            assign res_nxt = {s, res[WIDTH-1:1]};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode; start is ignored while running.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register only.
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Datapath: operand shifting, carry, counter and result publication.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_a  <= '0;
            sh_b  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            sh_a  <= a_in;
            sh_b  <= b_in;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (state == RUN) begin
            sh_a  <= sh_a >> 1;
            sh_b  <= sh_b >> 1;
            carry <= carry_nxt;
            res   <= res_nxt;
            cnt   <= cnt + CW'(1);
            if (last) begin
                sum  <= res_nxt;
                cout <= carry_nxt;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH = 4, 8 and 1.

module tb_serial_add_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       st4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;
    logic       st8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       st1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;

    int total = 0;
    int bad   = 0;

    serial_add_ctrl #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst(rst), .start(st4), .a_in(a4), .b_in(b4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4));
    serial_add_ctrl #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .start(st8), .a_in(a8), .b_in(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));
    serial_add_ctrl #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .start(st1), .a_in(a1), .b_in(b1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Present operands for one cycle; returns in the cycle after the accepting edge.
    task automatic start4(input logic [3:0] a, input logic [3:0] b);
        st4 = 1'b1; a4 = a; b4 = b;
        @(negedge clk);
        st4 = 1'b0;
    endtask

    task automatic start8(input logic [7:0] a, input logic [7:0] b);
        st8 = 1'b1; a8 = a; b8 = b;
        @(negedge clk);
        st8 = 1'b0;
    endtask

    // Expect 4 busy cycles, then the done cycle carrying the result.
    task automatic wait4(input string tag, input logic [3:0] es, input logic ec);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_busy"}, busy4, 1'b1);
            chk({tag, "_nodone"}, done4, 1'b0);
            @(negedge clk);
        end
        chk({tag, "_done"}, done4, 1'b1);
        chk({tag, "_busylow"}, busy4, 1'b0);
        chk({tag, "_sum"}, sum4, es);
        chk({tag, "_cout"}, cout4, ec);
    endtask

    initial begin
        int ndone;
        logic [3:0] cap_sum;
        logic cap_cout;

        rst = 1'b1;
        st4 = 0; a4 = 0; b4 = 0;
        st8 = 0; a8 = 0; b8 = 0;
        st1 = 0; a1 = 0; b1 = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy4", busy4, 0);
        chk("rst_done4", done4, 0);
        chk("rst_sum4", sum4, 0);
        chk("rst_cout4", cout4, 0);
        chk("rst_busy1", busy1, 0);
        rst = 1'b0;
        @(negedge clk);

        // 3 + 5
        start4(4'd3, 4'd5);
        wait4("t3p5", 4'd8, 1'b0);
        @(negedge clk);
        chk("t3p5_pulse", done4, 0);
        chk("t3p5_hold", sum4, 8);

        // full ripple
        start4(4'd15, 4'd1);
        wait4("t15p1", 4'd0, 1'b1);
        @(negedge clk);

        // 15 + 15 then back-to-back 0 + 0 while done is high
        start4(4'd15, 4'd15);
        wait4("t15p15", 4'd14, 1'b1);
        start4(4'd0, 4'd0);
        wait4("b2b", 4'd0, 1'b0);
        @(negedge clk);
        chk("b2b_idle", done4, 0);
        chk("b2b_idlebusy", busy4, 0);

        // start while busy is ignored
        start4(4'd6, 4'd7);
        @(negedge clk);
        chk("ign_busy", busy4, 1);
        st4 = 1'b1; a4 = 4'd1; b4 = 4'd1;
        @(negedge clk);
        st4 = 1'b0;
        ndone = 0; cap_sum = '0; cap_cout = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (done4) begin
                ndone++;
                cap_sum = sum4;
                cap_cout = cout4;
            end
            @(negedge clk);
        end
        chk("ign_ndone", ndone, 1);
        chk("ign_sum", cap_sum, 13);
        chk("ign_cout", cap_cout, 0);

        // WIDTH=8: complete one op so sum is nonzero, then abort another
        start8(8'd1, 8'd2);
        repeat (7) @(negedge clk);
        chk("w8a_busy", busy8, 1);
        chk("w8a_midsum", sum8, 0);
        @(negedge clk);
        chk("w8a_done", done8, 1);
        chk("w8a_sum", sum8, 3);
        @(negedge clk);
        start8(8'd200, 8'd100);
        repeat (2) @(negedge clk);
        chk("abort_busy", busy8, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy0", busy8, 0);
        chk("abort_done0", done8, 0);
        chk("abort_sum0", sum8, 0);
        chk("abort_cout0", cout8, 0);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            if (done8) ndone++;
            @(negedge clk);
        end
        chk("abort_nodone", ndone, 0);
        start8(8'd255, 8'd1);
        repeat (7) @(negedge clk);
        chk("w8b_busy", busy8, 1);
        chk("w8b_nodone", done8, 0);
        @(negedge clk);
        chk("w8b_done", done8, 1);
        chk("w8b_sum", sum8, 0);
        chk("w8b_cout", cout8, 1);
        @(negedge clk);

        // WIDTH=1 exhaustive
        for (int k = 0; k < 4; k++) begin
            logic [1:0] ab;
            logic [1:0] exp2;
            ab = 2'(k);
            exp2 = 2'(ab[1]) + 2'(ab[0]);
            st1 = 1'b1; a1 = ab[1]; b1 = ab[0];
            @(negedge clk);
            st1 = 1'b0;
            chk("w1_busy", busy1, 1);
            chk("w1_nodone", done1, 0);
            @(negedge clk);
            chk("w1_done", done1, 1);
            chk("w1_sum", sum1, exp2[0]);
            chk("w1_cout", cout1, exp2[1]);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Sequencer that performs a WIDTH-bit unsigned addition one bit per clock. It drives a single 1-bit adder cell, built from two `half_adder` instances plus an OR for carry-out. The block owns the operand shift registers, the carry flop, the bit counter and a start/busy/done handshake. Upstream logic presents operands on a start pulse and collects a stable result after a fixed WIDTH-cycle latency.

## Interface
- WIDTH, 8, operand and result width in bits; legal range is 1 to 32.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when the block can accept (IDLE or DONE).
- a_in  input  WIDTH  operand A; captured on the accepting edge.
- b_in  input  WIDTH  operand B; captured on the accepting edge.
- busy  output  1  high while the addition is in progress (RUN).
- done  output  1  one-cycle pulse; sum and cout are valid from this cycle.
- sum  output  WIDTH  registered result; holds until the next completion.
- cout  output  1  registered carry-out of the MSB; holds with sum.

## Operation
- One clock domain. Reset is synchronous and active-high.
- Reset values:
  - state = IDLE
  - busy = 0, done = 0
  - sum = 0, cout = 0
  - carry flop = 0, bit counter = 0
  - shift registers = 0
- States:
  - IDLE: wait for start.
  - RUN: shift one bit per cycle.
  - DONE: publish the result for one cycle.
- IDLE -> RUN when start = 1:
  - a_in is loaded into shift register A; b_in into shift register B.
  - Carry flop and counter are cleared.
- RUN, every cycle:
  - Cell inputs are A[0], B[0] and carry.
  - First half_adder produces p = A[0]^B[0] and g1 = A[0]&B[0].
  - Second half_adder produces s = p^carry and g2 = p&carry.
  - Next carry = g1|g2.
  - s is shifted into the result shift register from the MSB side.
  - A and B shift right by one. Counter increments.
- RUN -> DONE on the edge where counter == WIDTH-1, i.e. the last bit is processed:
  - sum is loaded with the completed result, including the final s.
  - cout is loaded with the final carry.
- DONE, for exactly one cycle:
  - done = 1, busy = 0.
  - If start = 1: accept new operands and go to RUN (back-to-back). Otherwise go to IDLE.
- start is ignored while in RUN. Operands are not re-sampled and no error is flagged.
- sum and cout change only on the completion edge. They are never visible mid-computation.
- Arithmetic is unsigned; {cout, sum} = a_in + b_in, i.e. WIDTH+1 bits.
- WIDTH = 1: RUN lasts one cycle; the counter compare is against 0.
- Counter width is clog2(WIDTH) with a minimum of 1.
- rst during RUN or DONE:
  - The operation is aborted and the state returns to IDLE.
  - All registers, including sum and cout, return to their reset values on that edge.
  - No done pulse is produced.

## Timing
- Start accepted at edge E0. busy is high in the cycles after E0 through E(WIDTH-1), i.e. WIDTH cycles.
- Completion edge is E(WIDTH). At that edge sum/cout update and done goes high; busy is low in that cycle.
- Latency from the accepting edge to done high is WIDTH cycles.
- Back-to-back throughput is one result per WIDTH+1 cycles: WIDTH RUN cycles plus one DONE cycle, with start held during DONE.
- done and busy are never high in the same cycle.
- All outputs are registered, with no combinational path from the inputs.

## Test plan
- WIDTH=4, a_in=3, b_in=5, start pulsed one cycle:
  - busy high for 4 cycles, then done for 1 cycle.
  - sum=8, cout=0.
- WIDTH=4, a_in=15, b_in=1 -> sum=0, cout=1 (full carry ripple).
- WIDTH=4, a_in=15, b_in=15 -> sum=14, cout=1. Then start with a_in=b_in=0 while done is high -> immediate RUN, next done gives sum=0, cout=0.
- WIDTH=4, a_in=6, b_in=7:
  - Two cycles later, while busy, assert start with a_in=1, b_in=1 -> ignored.
  - Result is sum=13, cout=0, and exactly one done pulse.
- WIDTH=8, a_in=200, b_in=100, rst asserted on the third RUN cycle:
  - Next cycle: busy=0, done=0, sum=0, cout=0.
  - No done pulse follows.
  - A fresh start with a_in=255, b_in=1 -> sum=0, cout=1 after 8 cycles.
- WIDTH=1, exhaustive a/b in {0,1}:
  - done one cycle after each accepting edge.
  - Results are (0,0)->0/0, (0,1)->1/0, (1,0)->1/0, (1,1)->0/1.
